risc_eunit_pipe: RTL and testbench

Parametrised successor to the 8-bit execution unit. It sits between the register file (operands in, writeback out) and data memory. The block registers ALU results with a valid/ready issue handshake and adds status flags. Load/store is a multi-cycle request/acknowledge FSM that stalls issue until memory completes.

---
 rtl/risc_pkg.sv | 31 +++
 rtl/risc_alu.sv | 88 ++++++++
 rtl/risc_eunit_pipe.sv | 153 +++++++++++++++
 tb/tb_risc_eunit_pipe.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared definitions for the execution unit: opcodes, flag bit positions and FSM states.
package risc_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_INC = 4'h6;
  localparam logic [3:0] OP_DEC = 4'h7;
  localparam logic [3:0] OP_NOT = 4'h8;
  localparam logic [3:0] OP_NEG = 4'h9;
  localparam logic [3:0] OP_SHR = 4'hA;
  localparam logic [3:0] OP_SHL = 4'hB;
  localparam logic [3:0] OP_ROR = 4'hC;
  localparam logic [3:0] OP_ROL = 4'hD;
  localparam logic [3:0] OP_LD  = 4'hE;
  localparam logic [3:0] OP_ST  = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

endpackage

// File: rtl/risc_alu.sv
// Combinational ALU: result plus {N,Z,C,V}. Arithmetic runs one bit wider so the
// top bit is the carry (add/inc) or borrow (sub/dec/neg).
module risc_alu
  import risc_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [3:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] rslt,
  output logic [3:0]    flags
);

  logic [DW:0]   wide;
  logic [DW:0]   one_w;
  logic          c;
  logic          v;

  assign one_w = {{DW{1'b0}}, 1'b1};

  always_comb begin
    wide  = '0;
    rslt  = '0;
    c     = 1'b0;
    v     = 1'b0;
    flags = '0;
    case (op)
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        rslt = wide[DW-1:0];
        c    = wide[DW];
        v    = (a[DW-1] == b[DW-1]) && (rslt[DW-1] != a[DW-1]);
      end
      OP_SUB: begin
        wide = {1'b0, a} - {1'b0, b};
        rslt = wide[DW-1:0];
        c    = wide[DW];
        v    = (a[DW-1] != b[DW-1]) && (rslt[DW-1] != a[DW-1]);
      end
      OP_INC: begin
        wide = {1'b0, a} + one_w;
        rslt = wide[DW-1:0];
        c    = wide[DW];
        v    = ~a[DW-1] & rslt[DW-1];
      end
      OP_DEC: begin
        wide = {1'b0, a} - one_w;
        rslt = wide[DW-1:0];
        c    = wide[DW];
        v    = a[DW-1] & ~rslt[DW-1];
      end
      OP_NEG: begin
        // Only the most negative value overflows when negated
        wide = '0 - {1'b0, a};
        rslt = wide[DW-1:0];
        c    = wide[DW];
        v    = a[DW-1] & rslt[DW-1];
      end
      OP_AND: rslt = a & b;
      OP_OR:  rslt = a | b;
      OP_XOR: rslt = a ^ b;
      OP_NOT: rslt = ~a;
      OP_SHR: begin
        rslt = {1'b0, a[DW-1:1]};
        c    = a[0];
      end
      OP_SHL: begin
        rslt = {a[DW-2:0], 1'b0};
        c    = a[DW-1];
      end
      OP_ROR: begin
        rslt = {a[0], a[DW-1:1]};
        c    = a[0];
      end
      OP_ROL: begin
        rslt = {a[DW-2:0], a[DW-1]};
        c    = a[DW-1];
      end
      default: rslt = '0;
    endcase
    flags[FLAG_N] = rslt[DW-1];
    flags[FLAG_Z] = (rslt == '0);
    flags[FLAG_C] = c;
    flags[FLAG_V] = v;
  end

endmodule

// File: rtl/risc_eunit_pipe.sv
// Execution unit with valid/ready issue, registered writeback and a load/store FSM.
// Status flags are built only when EUNIT_FLAGS_EN is defined; otherwise flags read 0.
module risc_eunit_pipe
  import risc_pkg::*;
#(
  parameter int DW  = 8,
  parameter int AW  = 4,
  parameter int RAW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_vld,
  output logic           in_rdy,
  input  logic [3:0]     opcode,
  input  logic [DW-1:0]  oprnd_a,
  input  logic [DW-1:0]  oprnd_b,
  input  logic [RAW-1:0] dstin,
  input  logic [AW-1:0]  dmaddrin,
  output logic           dmenbl,
  output logic           rdwr,
  output logic [AW-1:0]  dmaddr,
  output logic [DW-1:0]  dmdatain,
  input  logic           dm_ack,
  input  logic [DW-1:0]  dmdataout,
  output logic [DW-1:0]  rslt,
  output logic [RAW-1:0] dst,
  output logic           reg_wr_vld,
  output logic           load_op,
  output logic [3:0]     flags
);

  state_t         state_q, state_d;
  logic [DW-1:0]  rslt_q, rslt_d;
  logic [RAW-1:0] dst_q, dst_d;
  logic [RAW-1:0] ld_dst_q, ld_dst_d;
  logic           reg_wr_vld_q, reg_wr_vld_d;
  logic           load_op_q, load_op_d;
  logic           rdwr_q, rdwr_d;
  logic [AW-1:0]  dmaddr_q, dmaddr_d;
  logic [DW-1:0]  dmdatain_q, dmdatain_d;
  logic [DW-1:0]  alu_rslt;
  logic [3:0]     alu_flags;
  logic           accept;
  logic           is_mem_op;
  logic           is_alu_wb;

  risc_alu #(.DW(DW)) u_alu (
    .op    (opcode),
    .a     (oprnd_a),
    .b     (oprnd_b),
    .rslt  (alu_rslt),
    .flags (alu_flags)
  );

  assign in_rdy    = (state_q == S_IDLE);
  assign accept    = in_vld && in_rdy;
  assign is_mem_op = (opcode == OP_LD) || (opcode == OP_ST);
  assign is_alu_wb = accept && !is_mem_op && (opcode != OP_NOP);

  always_comb begin
    state_d      = state_q;
    rslt_d       = rslt_q;
    dst_d        = dst_q;
    ld_dst_d     = ld_dst_q;
    reg_wr_vld_d = 1'b0;
    load_op_d    = 1'b0;
    rdwr_d       = rdwr_q;
    dmaddr_d     = dmaddr_q;
    dmdatain_d   = dmdatain_q;
    case (state_q)
      S_IDLE: begin
        if (accept && is_mem_op) begin
          state_d  = S_REQ;
          dmaddr_d = dmaddrin;
          rdwr_d   = (opcode == OP_LD);
          ld_dst_d = dstin;
          if (opcode == OP_ST) dmdatain_d = oprnd_a;
        end else if (is_alu_wb) begin
          rslt_d       = alu_rslt;
          dst_d        = dstin;
          reg_wr_vld_d = 1'b1;
        end
      end
      S_REQ: begin
        // Read data is only valid alongside the acknowledge, so capture it here
        if (dm_ack) begin
          state_d = S_IDLE;
          if (rdwr_q) begin
            rslt_d       = dmdataout;
            dst_d        = ld_dst_q;
            reg_wr_vld_d = 1'b1;
            load_op_d    = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rslt_q       <= '0;
      dst_q        <= '0;
      ld_dst_q     <= '0;
      reg_wr_vld_q <= 1'b0;
      load_op_q    <= 1'b0;
      rdwr_q       <= 1'b0;
      dmaddr_q     <= '0;
      dmdatain_q   <= '0;
    end else begin
      state_q      <= state_d;
      rslt_q       <= rslt_d;
      dst_q        <= dst_d;
      ld_dst_q     <= ld_dst_d;
      reg_wr_vld_q <= reg_wr_vld_d;
      load_op_q    <= load_op_d;
      rdwr_q       <= rdwr_d;
      dmaddr_q     <= dmaddr_d;
      dmdatain_q   <= dmdatain_d;
    end
  end

`ifdef EUNIT_FLAGS_EN
  logic [3:0] flags_q, flags_d;

  always_comb begin
    flags_d = flags_q;
    if (is_alu_wb) flags_d = alu_flags;
  end

  always_ff @(posedge clk) begin
    if (rst) flags_q <= '0;
    else     flags_q <= flags_d;
  end

  assign flags = flags_q;
`else
  logic unused_alu_flags;
  assign unused_alu_flags = ^alu_flags;
  assign flags = 4'b0000;
`endif

  assign dmenbl     = (state_q == S_REQ);
  assign rdwr       = rdwr_q;
  assign dmaddr     = dmaddr_q;
  assign dmdatain   = dmdatain_q;
  assign rslt       = rslt_q;
  assign dst        = dst_q;
  assign reg_wr_vld = reg_wr_vld_q;
  assign load_op    = load_op_q;

endmodule

// File: tb/tb_risc_eunit_pipe.sv
// Randomised self-checking bench for risc_eunit_pipe against an arithmetic reference model.
module tb_risc_eunit_pipe;

  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int RAW = 3;

`ifdef EUNIT_FLAGS_EN
  localparam logic [3:0] FLAG_MASK = 4'hF;
`else
  localparam logic [3:0] FLAG_MASK = 4'h0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           in_vld;
  logic           in_rdy;
  logic [3:0]     opcode;
  logic [DW-1:0]  oprnd_a;
  logic [DW-1:0]  oprnd_b;
  logic [RAW-1:0] dstin;
  logic [AW-1:0]  dmaddrin;
  logic           dmenbl;
  logic           rdwr;
  logic [AW-1:0]  dmaddr;
  logic [DW-1:0]  dmdatain;
  logic           dm_ack;
  logic [DW-1:0]  dmdataout;
  logic [DW-1:0]  rslt;
  logic [RAW-1:0] dst;
  logic           reg_wr_vld;
  logic           load_op;
  logic [3:0]     flags;

  int checks   = 0;
  int failures = 0;

  // Architectural state as the reference model sees it
  logic [DW-1:0]  exp_rslt;
  logic [RAW-1:0] exp_dst;
  logic [3:0]     exp_flags;

  risc_eunit_pipe #(.DW(DW), .AW(AW), .RAW(RAW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_vld     (in_vld),
    .in_rdy     (in_rdy),
    .opcode     (opcode),
    .oprnd_a    (oprnd_a),
    .oprnd_b    (oprnd_b),
    .dstin      (dstin),
    .dmaddrin   (dmaddrin),
    .dmenbl     (dmenbl),
    .rdwr       (rdwr),
    .dmaddr     (dmaddr),
    .dmdatain   (dmdatain),
    .dm_ack     (dm_ack),
    .dmdataout  (dmdataout),
    .rslt       (rslt),
    .dst        (dst),
    .reg_wr_vld (reg_wr_vld),
    .load_op    (load_op),
    .flags      (flags)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {result[7:0], N, Z, C, V} computed with signed/unsigned integer arithmetic
  function automatic logic [11:0] model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int ua, ub, sa, sb, r, s;
    bit c, v;
    ua = int'(a);
    ub = int'(b);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    r = 0; s = 0; c = 0; v = 0;
    case (op)
      4'h1: begin r = (ua + ub) % 256; c = (ua + ub) > 255; s = sa + sb; v = (s > 127) || (s < -128); end
      4'h2: begin r = (ua - ub + 256) % 256; c = ua < ub; s = sa - sb; v = (s > 127) || (s < -128); end
      4'h3: r = ua & ub;
      4'h4: r = ua | ub;
      4'h5: r = ua ^ ub;
      4'h6: begin r = (ua + 1) % 256; c = (ua == 255); v = (sa + 1) > 127; end
      4'h7: begin r = (ua + 255) % 256; c = (ua == 0); v = (sa - 1) < -128; end
      4'h8: r = 255 - ua;
      4'h9: begin r = (256 - ua) % 256; c = (ua != 0); v = (-sa) > 127; end
      4'hA: begin r = ua / 2; c = (ua % 2) == 1; end
      4'hB: begin r = (ua * 2) % 256; c = ua >= 128; end
      4'hC: begin r = ua / 2 + (ua % 2) * 128; c = (ua % 2) == 1; end
      4'hD: begin r = (ua * 2) % 256 + ua / 128; c = ua >= 128; end
      default: r = 0;
    endcase
    return {r[7:0], r >= 128, r == 0, c, v};
  endfunction

  task automatic alu_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic [RAW-1:0] d);
    logic [11:0] m;
    in_vld    = 1'b1;
    opcode    = op;
    oprnd_a   = a;
    oprnd_b   = b;
    dstin     = d;
    dmaddrin  = AW'($urandom);
    dm_ack    = 1'($urandom_range(0, 1));
    dmdataout = DW'($urandom);
    m = model(op, a, b);
    if (op != 4'h0) begin
      exp_rslt  = m[11:4];
      exp_dst   = d;
      exp_flags = m[3:0];
    end
    @(posedge clk);
    @(negedge clk);
    $display("txn alu op=%0h a=%0h b=%0h dst=%0d rslt=%0h flags=%0h", op, a, b, d, rslt, flags);
    check_eq("alu_wr_vld", reg_wr_vld, op != 4'h0);
    check_eq("alu_rslt", rslt, exp_rslt);
    check_eq("alu_dst", dst, exp_dst);
    check_eq("alu_load_op", load_op, 1'b0);
    check_eq("alu_flags", flags, exp_flags & FLAG_MASK);
    check_eq("alu_in_rdy", in_rdy, 1'b1);
  endtask

  task automatic idle_cycle();
    in_vld    = 1'b0;
    dm_ack    = 1'($urandom_range(0, 1));
    dmdataout = DW'($urandom);
    @(posedge clk);
    @(negedge clk);
    $display("txn idle rslt=%0h", rslt);
    check_eq("idle_wr_vld", reg_wr_vld, 1'b0);
    check_eq("idle_rslt", rslt, exp_rslt);
    check_eq("idle_dmenbl", dmenbl, 1'b0);
  endtask

  task automatic mem_op(input bit is_ld, input logic [AW-1:0] addr, input logic [7:0] a,
                        input logic [RAW-1:0] d, input int delay, input logic [7:0] data,
                        input bit hold_add);
    logic [7:0]     ha, hb;
    logic [RAW-1:0] hd;
    logic [11:0]    m;
    ha = 8'($urandom);
    hb = 8'($urandom);
    hd = RAW'($urandom);
    dm_ack    = 1'b0;
    in_vld    = 1'b1;
    opcode    = is_ld ? 4'hE : 4'hF;
    oprnd_a   = a;
    oprnd_b   = 8'($urandom);
    dstin     = d;
    dmaddrin  = addr;
    @(posedge clk);
    @(negedge clk);
    // Scramble the issue inputs so the latched copies are what gets checked
    dmaddrin = AW'($urandom);
    in_vld   = hold_add;
    opcode   = 4'h1;
    oprnd_a  = ha;
    oprnd_b  = hb;
    dstin    = hd;
    for (int k = 0; k <= delay; k++) begin
      check_eq("mem_dmenbl", dmenbl, 1'b1);
      check_eq("mem_rdwr", rdwr, is_ld);
      check_eq("mem_addr", dmaddr, addr);
      check_eq("mem_in_rdy", in_rdy, 1'b0);
      check_eq("mem_stall_wr", reg_wr_vld, 1'b0);
      if (!is_ld) check_eq("mem_st_data", dmdatain, a);
      if (k == delay) begin
        dm_ack    = 1'b1;
        dmdataout = data;
      end
      @(posedge clk);
      @(negedge clk);
    end
    dm_ack = 1'b0;
    $display("txn %s addr=%0h dst=%0d delay=%0d rslt=%0h", is_ld ? "ld" : "st", addr, d, delay, rslt);
    check_eq("mem_done_dmenbl", dmenbl, 1'b0);
    check_eq("mem_done_in_rdy", in_rdy, 1'b1);
    if (is_ld) begin
      exp_rslt = data;
      exp_dst  = d;
    end
    check_eq("mem_wr_vld", reg_wr_vld, is_ld);
    check_eq("mem_load_op", load_op, is_ld);
    check_eq("mem_rslt", rslt, exp_rslt);
    check_eq("mem_dst", dst, exp_dst);
    check_eq("mem_flags", flags, exp_flags & FLAG_MASK);
    if (hold_add) begin
      m = model(4'h1, ha, hb);
      exp_rslt  = m[11:4];
      exp_dst   = hd;
      exp_flags = m[3:0];
      @(posedge clk);
      @(negedge clk);
      $display("txn held add a=%0h b=%0h rslt=%0h", ha, hb, rslt);
      check_eq("held_wr_vld", reg_wr_vld, 1'b1);
      check_eq("held_rslt", rslt, exp_rslt);
      check_eq("held_dst", dst, exp_dst);
      check_eq("held_flags", flags, exp_flags & FLAG_MASK);
    end
    in_vld = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_in_rdy"}, in_rdy, 1'b1);
    check_eq({tag, "_dmenbl"}, dmenbl, 1'b0);
    check_eq({tag, "_rdwr"}, rdwr, 1'b0);
    check_eq({tag, "_dmaddr"}, dmaddr, '0);
    check_eq({tag, "_dmdatain"}, dmdatain, '0);
    check_eq({tag, "_rslt"}, rslt, '0);
    check_eq({tag, "_dst"}, dst, '0);
    check_eq({tag, "_wr_vld"}, reg_wr_vld, 1'b0);
    check_eq({tag, "_load_op"}, load_op, 1'b0);
    check_eq({tag, "_flags"}, flags, 4'h0);
  endtask

  initial begin
    rst = 1'b1; in_vld = 1'b0; opcode = '0; oprnd_a = '0; oprnd_b = '0;
    dstin = '0; dmaddrin = '0; dm_ack = 1'b0; dmdataout = '0;
    exp_rslt = '0; exp_dst = '0; exp_flags = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    alu_op(4'h1, 8'h00, 8'hff, 3'd1);
    idle_cycle();
    alu_op(4'h2, 8'h22, 8'hcc, 3'd2);
    check_eq("sub_borrow", flags[1], FLAG_MASK[1]);
    alu_op(4'h5, 8'h88, 8'hee, 3'd3);
    alu_op(4'hC, 8'hee, 8'h00, 3'd4);
    alu_op(4'hD, 8'h66, 8'h00, 3'd5);
    alu_op(4'hB, 8'h88, 8'h00, 3'd6);
    alu_op(4'h9, 8'h00, 8'h00, 3'd7);
    alu_op(4'h0, 8'h12, 8'h34, 3'd0);
    alu_op(4'h6, 8'h7f, 8'h00, 3'd1);
    alu_op(4'h7, 8'h80, 8'h00, 3'd2);
    idle_cycle();

    mem_op(1'b1, 4'h3, 8'h00, 3'd2, 2, 8'h5a, 1'b1);
    mem_op(1'b0, 4'h9, 8'h3c, 3'd0, 1, 8'h00, 1'b0);
    idle_cycle();

    for (int i = 0; i < 80; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 6)
        alu_op(4'($urandom_range(0, 13)), 8'($urandom), 8'($urandom), RAW'($urandom));
      else if (sel == 6)
        idle_cycle();
      else
        mem_op(1'($urandom_range(0, 1)), AW'($urandom), 8'($urandom), RAW'($urandom),
               $urandom_range(0, 3), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    // Abort a load with reset while the request is outstanding
    in_vld = 1'b1; opcode = 4'hE; dmaddrin = 4'h5; dstin = 3'd6; dm_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_vld = 1'b0;
    check_eq("abort_req", dmenbl, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_rslt = '0; exp_dst = '0; exp_flags = '0;
    $display("txn reset during ld request");
    check_all_zero("abort");
    dm_ack = 1'b1; dmdataout = 8'ha5;
    @(posedge clk);
    @(negedge clk);
    dm_ack = 1'b0;
    $display("txn late ack after abort");
    check_eq("late_ack_wr_vld", reg_wr_vld, 1'b0);
    check_eq("late_ack_rslt", rslt, '0);
    check_eq("late_ack_dmenbl", dmenbl, 1'b0);
    alu_op(4'h4, 8'h0f, 8'hf0, 3'd3);
    in_vld = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
